// File: rtl/power_seq.sv
// Runtime-exponent power unit: i_a^i_exp mod 2^OUT_W using right-to-left
// square-and-multiply on a single shared OUT_W x OUT_W multiplier.
//
// state | meaning
// IDLE  | waiting for a request, o_ready high
// MUL   | conditionally fold base into accumulator (exponent LSB set)
// SQR   | shift exponent, square base while more exponent bits remain
// DONE  | result presented, waiting for consumer handshake
module power_seq #(
   parameter int DATA_W = 8,
   parameter int EXP_W  = 4,
   parameter int OUT_W  = 32
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              i_valid,
   output logic              o_ready,
   input  logic [DATA_W-1:0] i_a,
   input  logic [EXP_W-1:0]  i_exp,
   output logic              o_valid,
   input  logic              i_ready,
   output logic [OUT_W-1:0]  o_output,
   output logic              o_overflow,
   output logic              o_busy
);

   typedef enum logic [1:0] {S_IDLE, S_MUL, S_SQR, S_DONE} state_t;

   state_t             r_state;
   state_t             w_next;
   logic [OUT_W-1:0]   r_acc;
   logic [OUT_W-1:0]   r_base;
   logic [EXP_W-1:0]   r_e;
   logic               r_ovf;
   logic [OUT_W-1:0]   r_out;
   logic               r_ovf_out;

   logic [OUT_W-1:0]   w_op_a;
   logic [2*OUT_W-1:0] w_prod;
   logic               w_prod_hi;
   logic [EXP_W-1:0]   w_e_shr;
   logic               w_accept;

   // One multiplier: MUL uses acc*base, SQR uses base*base.
   assign w_op_a    = (r_state == S_SQR) ? r_base : r_acc;
   assign w_prod    = w_op_a * r_base;
   assign w_prod_hi = |w_prod[2*OUT_W-1:OUT_W];
   assign w_e_shr   = r_e >> 1;
   assign w_accept  = (r_state == S_IDLE) && i_valid;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE: begin
            if (i_valid) begin
               w_next = (i_exp == '0) ? S_DONE : S_MUL;
            end
         end
         S_MUL:  w_next = S_SQR;
         S_SQR:  w_next = (w_e_shr != '0) ? S_MUL : S_DONE;
         S_DONE: begin
            if (i_ready) begin
               w_next = S_IDLE;
            end
         end
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_acc     <= '0;
         r_base    <= '0;
         r_e       <= '0;
         r_ovf     <= 1'b0;
         r_out     <= '0;
         r_ovf_out <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  r_base <= {{(OUT_W-DATA_W){1'b0}}, i_a};
                  r_e    <= i_exp;
                  r_acc  <= OUT_W'(1);
                  r_ovf  <= 1'b0;
                  if (i_exp == '0) begin
                     r_out     <= OUT_W'(1);
                     r_ovf_out <= 1'b0;
                  end
               end
            end
            S_MUL: begin
               if (r_e[0]) begin
                  r_acc <= w_prod[OUT_W-1:0];
                  r_ovf <= r_ovf | w_prod_hi;
               end
            end
            S_SQR: begin
               r_e <= w_e_shr;
               if (w_e_shr != '0) begin
                  r_base <= w_prod[OUT_W-1:0];
                  r_ovf  <= r_ovf | w_prod_hi;
               end else begin
                  // Last exponent bit consumed: publish the result registers.
                  r_out     <= r_acc;
                  r_ovf_out <= r_ovf;
               end
            end
            default: ;
         endcase
      end
   end

   assign o_ready    = (r_state == S_IDLE);
   assign o_valid    = (r_state == S_DONE);
   assign o_busy     = (r_state == S_MUL) || (r_state == S_SQR);
   assign o_output   = r_out;
   assign o_overflow = r_ovf_out;

endmodule

// File: tb/tb_power_seq.sv
// Self-checking bench for power_seq: directed cases plus randomized
// requests compared against a repeated-multiplication reference model.
module tb_power_seq;

   logic        clk;
   logic        reset_n;
   logic        i_valid;
   logic        o_ready;
   logic [7:0]  i_a;
   logic [3:0]  i_exp;
   logic        o_valid;
   logic        i_ready;
   logic [31:0] o_output;
   logic        o_overflow;
   logic        o_busy;

   int n_pass  = 0;
   int n_total = 0;

   power_seq #(.DATA_W(8), .EXP_W(4), .OUT_W(32)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .i_valid    (i_valid),
      .o_ready    (o_ready),
      .i_a        (i_a),
      .i_exp      (i_exp),
      .o_valid    (o_valid),
      .i_ready    (i_ready),
      .o_output   (o_output),
      .o_overflow (o_overflow),
      .o_busy     (o_busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: a^e as e successive multiplications; overflow if any
   // partial product leaves 32 bits (equivalently, true value >= 2^32).
   function automatic void model_pow(input int unsigned a, input int unsigned e,
                                     output logic [31:0] res, output logic ovf);
      logic [63:0] v;
      v   = 64'd1;
      ovf = 1'b0;
      for (int k = 0; k < int'(e); k++) begin
         v = v * 64'(a);
         if (v[63:32] != 32'h0) ovf = 1'b1;
         v = {32'h0, v[31:0]};
      end
      res = v[31:0];
   endfunction

   function automatic int model_lat(input int unsigned e);
      int nb;
      int unsigned t;
      nb = 0;
      t  = e;
      while (t != 0) begin
         nb++;
         t = t >> 1;
      end
      return 2 * nb;
   endfunction

   // Issue one request with i_ready high; returns result, latency in edges
   // after the accept edge, and o_ready in the cycle after the handshake.
   task automatic run_op(input logic [7:0] a, input logic [3:0] e,
                         output logic [31:0] res, output logic ovf,
                         output int lat, output logic rdy_after);
      int w;
      w = 0;
      i_ready = 1'b1;
      @(negedge clk);
      while (!o_ready && w < 100) begin
         @(negedge clk);
         w++;
      end
      i_valid = 1'b1;
      i_a     = a;
      i_exp   = e;
      @(negedge clk);
      i_valid = 1'b0;
      lat = 0;
      while (!o_valid && lat < 100) begin
         @(negedge clk);
         lat++;
      end
      res = o_output;
      ovf = o_overflow;
      @(negedge clk);
      rdy_after = o_ready;
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      i_valid = 1'b0;
      i_ready = 1'b1;
      i_a     = '0;
      i_exp   = '0;
      #12;
      n_total++;
      if ({o_ready, o_valid, o_busy, o_overflow} !== 4'b1000) $display("FAIL reset_flags got=%b want=1000", {o_ready, o_valid, o_busy, o_overflow});
      else n_pass++;
      n_total++;
      if (o_output !== 32'd0) $display("FAIL reset_output got=%0d want=0", o_output);
      else n_pass++;
      @(negedge clk);
      reset_n = 1'b1;
   endtask

   task automatic test_directed();
      logic [7:0]  ta [6] = '{8'd3, 8'd2, 8'd7, 8'd255, 8'd255, 8'd0};
      logic [3:0]  te [6] = '{4'd5, 4'd15, 4'd0, 4'd4, 4'd8, 4'd3};
      logic [31:0] tr [6] = '{32'd243, 32'd32768, 32'd1, 32'd4228250625, 32'd3357276161, 32'd0};
      logic        tv [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
      int          tl [6] = '{6, 8, 0, 6, 8, 4};
      logic [31:0] res;
      logic        ovf, rdy;
      int          lat;
      for (int i = 0; i < 6; i++) begin
         run_op(ta[i], te[i], res, ovf, lat, rdy);
         n_total++;
         if (res !== tr[i]) $display("FAIL dir_output[%0d] got=%0d want=%0d", i, res, tr[i]);
         else n_pass++;
         n_total++;
         if (ovf !== tv[i]) $display("FAIL dir_overflow[%0d] got=%b want=%b", i, ovf, tv[i]);
         else n_pass++;
         n_total++;
         if (lat !== tl[i]) $display("FAIL dir_latency[%0d] got=%0d want=%0d", i, lat, tl[i]);
         else n_pass++;
         n_total++;
         if (rdy !== 1'b1) $display("FAIL dir_ready_after[%0d] got=%b want=1", i, rdy);
         else n_pass++;
      end
   endtask

   task automatic test_backpressure();
      int w;
      w = 0;
      i_ready = 1'b0;
      @(negedge clk);
      i_valid = 1'b1;
      i_a     = 8'd5;
      i_exp   = 4'd3;
      @(negedge clk);
      i_valid = 1'b0;
      while (!o_valid && w < 100) begin
         @(negedge clk);
         w++;
      end
      n_total++;
      if (o_valid !== 1'b1) $display("FAIL bp_valid_timeout got=%b want=1", o_valid);
      else n_pass++;
      i_valid = 1'b1;
      i_a     = 8'd9;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         n_total++;
         if ({o_valid, o_ready} !== 2'b10 || o_output !== 32'd125) $display("FAIL bp_hold[%0d] got v/r=%b out=%0d want v/r=10 out=125", c, {o_valid, o_ready}, o_output);
         else n_pass++;
      end
      i_valid = 1'b0;
      i_ready = 1'b1;
      @(negedge clk);
      n_total++;
      if ({o_valid, o_ready, o_busy} !== 3'b010 || o_output !== 32'd125) $display("FAIL bp_release got v/r/b=%b out=%0d want v/r/b=010 out=125", {o_valid, o_ready, o_busy}, o_output);
      else n_pass++;
   endtask

   task automatic test_reset_midop();
      logic [31:0] res;
      logic        ovf, rdy;
      int          lat;
      @(negedge clk);
      i_valid = 1'b1;
      i_a     = 8'd3;
      i_exp   = 4'd15;
      @(negedge clk);
      i_valid = 1'b0;
      n_total++;
      if (o_busy !== 1'b1) $display("FAIL midop_busy got=%b want=1", o_busy);
      else n_pass++;
      @(negedge clk);
      @(negedge clk);
      #2;
      reset_n = 1'b0;
      #1;
      n_total++;
      if ({o_ready, o_valid, o_busy, o_overflow} !== 4'b1000 || o_output !== 32'd0) $display("FAIL midop_reset got r/v/b/o=%b out=%0d want 1000 out=0", {o_ready, o_valid, o_busy, o_overflow}, o_output);
      else n_pass++;
      @(negedge clk);
      reset_n = 1'b1;
      run_op(8'd4, 4'd2, res, ovf, lat, rdy);
      n_total++;
      if (res !== 32'd16 || ovf !== 1'b0) $display("FAIL midop_after got=%0d/%b want=16/0", res, ovf);
      else n_pass++;
   endtask

   task automatic test_back_to_back();
      logic [31:0] got_q [$];
      logic        gov_q [$];
      logic [31:0] exp_r;
      logic        exp_o;
      int          idx, cyc;
      idx = 0;
      cyc = 0;
      i_ready = 1'b1;
      @(negedge clk);
      i_valid = 1'b1;
      while ((idx < 10 || got_q.size() < 10) && cyc < 500) begin
         if (o_valid) begin
            got_q.push_back(o_output);
            gov_q.push_back(o_overflow);
         end
         if (o_ready && idx < 10) begin
            i_a   = 8'(idx);
            i_exp = 4'd8;
            idx++;
         end else if (o_ready) begin
            i_valid = 1'b0;
         end
         @(negedge clk);
         cyc++;
      end
      i_valid = 1'b0;
      n_total++;
      if (got_q.size() !== 10) $display("FAIL b2b_count got=%0d want=10", got_q.size());
      else n_pass++;
      for (int k = 0; k < got_q.size() && k < 10; k++) begin
         model_pow(k, 8, exp_r, exp_o);
         n_total++;
         if (got_q[k] !== exp_r || gov_q[k] !== exp_o) $display("FAIL b2b[%0d] got=%0d/%b want=%0d/%b", k, got_q[k], gov_q[k], exp_r, exp_o);
         else n_pass++;
      end
   endtask

   task automatic test_random();
      logic [31:0] res, exp_r;
      logic        ovf, exp_o, rdy;
      logic [7:0]  a;
      logic [3:0]  e;
      int          lat;
      for (int i = 0; i < 24; i++) begin
         a = 8'($urandom_range(0, 255));
         e = 4'($urandom_range(0, 15));
         model_pow(a, e, exp_r, exp_o);
         run_op(a, e, res, ovf, lat, rdy);
         n_total++;
         if (res !== exp_r || ovf !== exp_o) $display("FAIL rand[%0d] a=%0d e=%0d got=%0d/%b want=%0d/%b", i, a, e, res, ovf, exp_r, exp_o);
         else n_pass++;
         n_total++;
         if (lat !== model_lat(e)) $display("FAIL rand_latency[%0d] e=%0d got=%0d want=%0d", i, e, lat, model_lat(e));
         else n_pass++;
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_backpressure();
      test_reset_midop();
      test_back_to_back();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
